// File: rtl/gerenciador_partida.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gerenciador_partida                                        |
// | Description : Naval-battle match controller for a LINHAS x COLUNAS       |
// |               board. Latches the prepared ship map, arbitrates shots     |
// |               (hit / miss / repeat / out of range), tracks remaining     |
// |               targets and shots, runs the win/lose FSM and drives timed  |
// |               RGB feedback.                                              |
// | Ports       : clock, reset_n (async, active low)                         |
// |               modo[1:0]            00 off, 01 preparation, 1x attack     |
// |               confirmar            one-cycle confirm pulse               |
// |               coord_linha/coluna   shot coordinates                      |
// |               mapa[N-1:0]          ship map, bit = linha*COLUNAS+coluna  |
// |               mapa_atual, tiros_mat, acertos_mat   board matrices        |
// |               tiros_restantes, alvos_restantes     match counters        |
// |               estado[2:0]          0 off,1 prep,2 attack,3 win,4 lose    |
// |               led_r, led_g, led_b  status LEDs, active high              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module gerenciador_partida #(
    parameter int LINHAS          = 7,
    parameter int COLUNAS         = 5,
    parameter int MAX_TIROS       = 16,
    parameter int FEEDBACK_CICLOS = 1000,
    localparam int N  = LINHAS * COLUNAS,
    localparam int LW = ($clog2(LINHAS) < 1) ? 1 : $clog2(LINHAS),
    localparam int CW = ($clog2(COLUNAS) < 1) ? 1 : $clog2(COLUNAS),
    localparam int TW = ($clog2(MAX_TIROS + 1) < 1) ? 1 : $clog2(MAX_TIROS + 1),
    localparam int AW = ($clog2(N + 1) < 1) ? 1 : $clog2(N + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [1:0]    modo,
    input  logic          confirmar,
    input  logic [LW-1:0] coord_linha,
    input  logic [CW-1:0] coord_coluna,
    input  logic [N-1:0]  mapa,
    output logic [N-1:0]  mapa_atual,
    output logic [N-1:0]  tiros_mat,
    output logic [N-1:0]  acertos_mat,
    output logic [TW-1:0] tiros_restantes,
    output logic [AW-1:0] alvos_restantes,
    output logic [2:0]    estado,
    output logic          led_r,
    output logic          led_g,
    output logic          led_b
);

    localparam int FW = ($clog2(FEEDBACK_CICLOS + 1) < 1) ? 1 : $clog2(FEEDBACK_CICLOS + 1);

    localparam logic [2:0] c_desligado  = 3'd0;
    localparam logic [2:0] c_preparacao = 3'd1;
    localparam logic [2:0] c_ataque     = 3'd2;
    localparam logic [2:0] c_vitoria    = 3'd3;
    localparam logic [2:0] c_derrota    = 3'd4;

    // {r,g,b}
    localparam logic [2:0] c_rgb_off   = 3'b000;
    localparam logic [2:0] c_rgb_verm  = 3'b100;
    localparam logic [2:0] c_rgb_verde = 3'b010;
    localparam logic [2:0] c_rgb_azul  = 3'b001;

    logic [2:0]    r_estado, w_estado_prox;
    logic [N-1:0]  r_mapa, w_mapa_prox;
    logic [N-1:0]  r_tiros_mat, w_tiros_mat_prox;
    logic [N-1:0]  r_acertos_mat, w_acertos_mat_prox;
    logic [TW-1:0] r_tiros, w_tiros_prox;
    logic [AW-1:0] r_alvos, w_alvos_prox;
    logic [FW-1:0] r_flash_cnt, w_flash_cnt_prox;
    logic [2:0]    r_flash_rgb, w_flash_rgb_prox;
    logic [2:0]    r_rgb, w_rgb_prox;

    logic          w_em_faixa, w_repetido, w_acerto, w_fim, w_disparo;
    logic [N-1:0]  w_mascara;

    function automatic logic [AW-1:0] contar_navios(input logic [N-1:0] m);
        logic [AW-1:0] total;
        total = '0;
        for (int j = 0; j < N; j++) begin
            total = total + AW'(m[j]);
        end
        return total;
    endfunction

    // Shot decode: one-hot mask of the targeted cell, empty when out of range
    // so that the repeat/hit tests below never look outside the board.
    always_comb begin
        w_em_faixa = (32'(coord_linha) < 32'(LINHAS)) && (32'(coord_coluna) < 32'(COLUNAS));
        w_mascara  = w_em_faixa ?
                     (N'(1) << (32'(coord_linha) * 32'(COLUNAS) + 32'(coord_coluna))) : '0;
        w_repetido = |(r_tiros_mat & w_mascara);
        w_acerto   = |(r_mapa & w_mascara);
    end

    // Once a match has ended (counters already at zero) the FSM moves on at
    // this edge and any shot presented alongside is discarded.
    assign w_fim     = (r_alvos == '0) || (r_tiros == '0);
    assign w_disparo = modo[1] && confirmar && (r_estado == c_ataque) && !w_fim;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= c_desligado;
        end else begin
            r_estado <= w_estado_prox;
        end
    end

    // Next-state logic: modo dominates, then end-of-match detection
    always_comb begin
        w_estado_prox = r_estado;
        if (modo == 2'b00) begin
            w_estado_prox = c_desligado;
        end else if (modo == 2'b01) begin
            w_estado_prox = c_preparacao;
        end else begin
            case (r_estado)
                c_preparacao: w_estado_prox = c_ataque;
                c_ataque: begin
                    if (r_alvos == '0) begin
                        w_estado_prox = c_vitoria;
                    end else if (r_tiros == '0) begin
                        w_estado_prox = c_derrota;
                    end
                end
                default: w_estado_prox = r_estado;
            endcase
        end
    end

    // Board and counter datapath
    always_comb begin
        w_mapa_prox        = r_mapa;
        w_tiros_mat_prox   = r_tiros_mat;
        w_acertos_mat_prox = r_acertos_mat;
        w_tiros_prox       = r_tiros;
        w_alvos_prox       = r_alvos;
        w_flash_rgb_prox   = r_flash_rgb;
        w_flash_cnt_prox   = (r_flash_cnt != '0) ? r_flash_cnt - FW'(1) : '0;

        if (modo == 2'b00) begin
            w_mapa_prox        = '0;
            w_tiros_mat_prox   = '0;
            w_acertos_mat_prox = '0;
            w_tiros_prox       = '0;
            w_alvos_prox       = '0;
        end else if (modo == 2'b01) begin
            if (r_estado != c_preparacao) begin
                // Re-entering preparation restarts the match on the kept map,
                // so the target count follows the map with no hits recorded.
                w_tiros_mat_prox   = '0;
                w_acertos_mat_prox = '0;
                w_tiros_prox       = TW'(MAX_TIROS);
                w_alvos_prox       = contar_navios(r_mapa);
            end else if (confirmar) begin
                w_mapa_prox  = mapa;
                w_alvos_prox = contar_navios(mapa);
            end
        end else if (w_disparo) begin
            w_flash_cnt_prox = FW'(FEEDBACK_CICLOS);
            if (!w_em_faixa || w_repetido) begin
                w_flash_rgb_prox = c_rgb_azul;
            end else begin
                w_tiros_mat_prox = r_tiros_mat | w_mascara;
                w_tiros_prox     = (r_tiros != '0) ? r_tiros - TW'(1) : '0;
                if (w_acerto) begin
                    w_acertos_mat_prox = r_acertos_mat | w_mascara;
                    w_alvos_prox       = (r_alvos != '0) ? r_alvos - AW'(1) : '0;
                    w_flash_rgb_prox   = c_rgb_verde;
                end else begin
                    w_flash_rgb_prox   = c_rgb_verm;
                end
            end
        end

        // Flashes only live inside the attack phase
        if (w_estado_prox != c_ataque) begin
            w_flash_cnt_prox = '0;
        end
    end

    // Output logic: next LED colour, registered below
    always_comb begin
        if (w_flash_cnt_prox != '0) begin
            w_rgb_prox = w_flash_rgb_prox;
        end else begin
            case (w_estado_prox)
                c_preparacao: w_rgb_prox = c_rgb_azul;
                c_vitoria:    w_rgb_prox = c_rgb_verde;
                c_derrota:    w_rgb_prox = c_rgb_verm;
                default:      w_rgb_prox = c_rgb_off;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mapa        <= '0;
            r_tiros_mat   <= '0;
            r_acertos_mat <= '0;
            r_tiros       <= '0;
            r_alvos       <= '0;
            r_flash_cnt   <= '0;
            r_flash_rgb   <= c_rgb_off;
            r_rgb         <= c_rgb_off;
        end else begin
            r_mapa        <= w_mapa_prox;
            r_tiros_mat   <= w_tiros_mat_prox;
            r_acertos_mat <= w_acertos_mat_prox;
            r_tiros       <= w_tiros_prox;
            r_alvos       <= w_alvos_prox;
            r_flash_cnt   <= w_flash_cnt_prox;
            r_flash_rgb   <= w_flash_rgb_prox;
            r_rgb         <= w_rgb_prox;
        end
    end

    assign mapa_atual      = r_mapa;
    assign tiros_mat       = r_tiros_mat;
    assign acertos_mat     = r_acertos_mat;
    assign tiros_restantes = r_tiros;
    assign alvos_restantes = r_alvos;
    assign estado          = r_estado;
    assign led_r           = r_rgb[2];
    assign led_g           = r_rgb[1];
    assign led_b           = r_rgb[0];

endmodule
`default_nettype wire

// File: tb/tb_gerenciador_partida.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_gerenciador_partida                                     |
// | Description : Scoreboard bench for gerenciador_partida. A driver applies |
// |               directed and random stimulus on the falling edge and       |
// |               pushes the reference model's expected outputs; a monitor   |
// |               pops and compares just after each rising edge.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_gerenciador_partida;

    localparam int LINHAS    = 7;
    localparam int COLUNAS   = 5;
    localparam int MAX_TIROS = 16;
    localparam int FB        = 12;
    localparam int N  = LINHAS * COLUNAS;
    localparam int LW = ($clog2(LINHAS) < 1) ? 1 : $clog2(LINHAS);
    localparam int CW = ($clog2(COLUNAS) < 1) ? 1 : $clog2(COLUNAS);
    localparam int TW = ($clog2(MAX_TIROS + 1) < 1) ? 1 : $clog2(MAX_TIROS + 1);
    localparam int AW = ($clog2(N + 1) < 1) ? 1 : $clog2(N + 1);

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    modo = 2'b00;
    logic          confirmar = 1'b0;
    logic [LW-1:0] coord_linha = '0;
    logic [CW-1:0] coord_coluna = '0;
    logic [N-1:0]  mapa = '0;
    logic [N-1:0]  mapa_atual, tiros_mat, acertos_mat;
    logic [TW-1:0] tiros_restantes;
    logic [AW-1:0] alvos_restantes;
    logic [2:0]    estado;
    logic          led_r, led_g, led_b;

    always #5 clock = ~clock;

    gerenciador_partida #(
        .LINHAS(LINHAS), .COLUNAS(COLUNAS), .MAX_TIROS(MAX_TIROS), .FEEDBACK_CICLOS(FB)
    ) dut (
        .clock(clock), .reset_n(reset_n), .modo(modo), .confirmar(confirmar),
        .coord_linha(coord_linha), .coord_coluna(coord_coluna), .mapa(mapa),
        .mapa_atual(mapa_atual), .tiros_mat(tiros_mat), .acertos_mat(acertos_mat),
        .tiros_restantes(tiros_restantes), .alvos_restantes(alvos_restantes),
        .estado(estado), .led_r(led_r), .led_g(led_g), .led_b(led_b)
    );

    typedef struct packed {
        logic [2:0]    estado;
        logic [TW-1:0] tiros;
        logic [AW-1:0] alvos;
        logic [N-1:0]  mapa;
        logic [N-1:0]  tm;
        logic [N-1:0]  am;
        logic [2:0]    rgb;
    } snap_t;

    snap_t fila[$];
    int checks = 0;
    int failures = 0;

    // Reference model: game rules on plain arrays and integers
    int fase;            // 0 off, 1 prep, 2 attack, 3 win, 4 lose
    bit navio[N];
    bit tiro[N];
    bit acerto[N];
    int m_tiros, m_alvos, m_flash;
    logic [2:0] m_cor;   // {r,g,b}

    function automatic int alvos_vivos();
        int n = 0;
        for (int j = 0; j < N; j++) if (navio[j] && !acerto[j]) n++;
        return n;
    endfunction

    task automatic modelo(input bit rst, input logic [1:0] m, input bit conf,
                          input int l, input int c, input logic [N-1:0] mp);
        if (!rst) begin
            fase = 0; m_tiros = 0; m_alvos = 0; m_flash = 0; m_cor = 3'b000;
            for (int j = 0; j < N; j++) begin navio[j] = 0; tiro[j] = 0; acerto[j] = 0; end
            return;
        end
        if (m_flash > 0) m_flash--;
        if (m == 2'b00) begin
            fase = 0; m_tiros = 0; m_alvos = 0;
            for (int j = 0; j < N; j++) begin navio[j] = 0; tiro[j] = 0; acerto[j] = 0; end
        end else if (m == 2'b01) begin
            if (fase != 1) begin
                fase = 1;
                for (int j = 0; j < N; j++) begin tiro[j] = 0; acerto[j] = 0; end
                m_tiros = MAX_TIROS;
                m_alvos = alvos_vivos();
            end else if (conf) begin
                for (int j = 0; j < N; j++) navio[j] = mp[j];
                m_alvos = alvos_vivos();
            end
        end else begin
            if (fase == 1) fase = 2;
            else if (fase == 2) begin
                if (m_alvos == 0) fase = 3;
                else if (m_tiros == 0) fase = 4;
                else if (conf) begin
                    m_flash = FB;
                    if (l >= LINHAS || c >= COLUNAS) m_cor = 3'b001;
                    else if (tiro[l * COLUNAS + c]) m_cor = 3'b001;
                    else begin
                        tiro[l * COLUNAS + c] = 1;
                        m_tiros--;
                        if (navio[l * COLUNAS + c]) begin
                            acerto[l * COLUNAS + c] = 1;
                            m_alvos--;
                            m_cor = 3'b010;
                        end else m_cor = 3'b100;
                    end
                end
            end
        end
        if (fase != 2) m_flash = 0;
    endtask

    function automatic snap_t esperado();
        snap_t s;
        s.estado = 3'(fase);
        s.tiros  = TW'(m_tiros);
        s.alvos  = AW'(m_alvos);
        for (int j = 0; j < N; j++) begin
            s.mapa[j] = navio[j]; s.tm[j] = tiro[j]; s.am[j] = acerto[j];
        end
        if (m_flash > 0) s.rgb = m_cor;
        else if (fase == 1) s.rgb = 3'b001;
        else if (fase == 3) s.rgb = 3'b010;
        else if (fase == 4) s.rgb = 3'b100;
        else s.rgb = 3'b000;
        return s;
    endfunction

    task automatic passo(input bit rst, input logic [1:0] m, input bit conf,
                         input int l, input int c, input logic [N-1:0] mp);
        @(negedge clock);
        reset_n = rst; modo = m; confirmar = conf;
        coord_linha = LW'(l); coord_coluna = CW'(c); mapa = mp;
        modelo(rst, m, conf, l, c, mp);
        fila.push_back(esperado());
    endtask

    task automatic ocioso(input int n, input logic [1:0] m, input logic [N-1:0] mp);
        for (int k = 0; k < n; k++) passo(1, m, 0, 0, 0, mp);
    endtask

    task automatic comparar(input string nome, input logic [63:0] atual, input logic [63:0] req);
        checks++;
        if (atual !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nome, atual, req, $time);
        end
    endtask

    // Monitor
    initial begin
        snap_t e;
        forever begin
            @(posedge clock);
            #1;
            if (fila.size() > 0) begin
                e = fila.pop_front();
                comparar("estado", 64'(estado), 64'(e.estado));
                comparar("tiros_restantes", 64'(tiros_restantes), 64'(e.tiros));
                comparar("alvos_restantes", 64'(alvos_restantes), 64'(e.alvos));
                comparar("mapa_atual", 64'(mapa_atual), 64'(e.mapa));
                comparar("tiros_mat", 64'(tiros_mat), 64'(e.tm));
                comparar("acertos_mat", 64'(acertos_mat), 64'(e.am));
                comparar("rgb", 64'({led_r, led_g, led_b}), 64'(e.rgb));
            end
        end
    end

    task automatic partida_aleatoria();
        logic [N-1:0] mp;
        int k, l, c, idx, r;
        mp = '0;
        k = $urandom_range(0, 5);
        for (int j = 0; j < k; j++) mp[$urandom_range(0, N - 1)] = 1'b1;
        passo(1, 2'b01, 0, 0, 0, mp);
        passo(1, 2'b01, 1, 0, 0, mp);
        ocioso($urandom_range(0, 2), 2'b01, mp);
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 199);
            if (r == 0) passo(0, 2'b10, 0, 0, 0, mp);
            else if (r < 3) passo(1, 2'b00, 0, 0, 0, mp);
            else if (r < 6) passo(1, 2'b01, $urandom_range(0, 1), 0, 0, mp);
            else begin
                if ($urandom_range(0, 1) == 1 && k > 0) begin
                    idx = $urandom_range(0, N - 1);
                    for (int j = 0; j < N; j++) if (mp[(idx + j) % N]) begin idx = (idx + j) % N; break; end
                    l = idx / COLUNAS; c = idx % COLUNAS;
                end else begin
                    l = $urandom_range(0, 7); c = $urandom_range(0, 7);
                end
                passo(1, 2'b10, $urandom_range(0, 1), l, c, mp);
            end
        end
    endtask

    // Driver
    initial begin
        logic [N-1:0] mp;
        // Reset
        repeat (2) passo(0, 2'b00, 0, 0, 0, '0);
        // Preparation with ships at 0, 6, 12
        mp = '0; mp[0] = 1'b1; mp[6] = 1'b1; mp[12] = 1'b1;
        passo(1, 2'b01, 0, 0, 0, mp);
        passo(1, 2'b01, 1, 0, 0, mp);
        ocioso(2, 2'b01, mp);
        // Attack: hit (0,0), watch the green flash expire
        passo(1, 2'b10, 0, 0, 0, mp);
        passo(1, 2'b10, 1, 0, 0, mp);
        ocioso(FB + 2, 2'b10, mp);
        // Repeat and out-of-range shots
        passo(1, 2'b10, 1, 0, 0, mp);
        ocioso(3, 2'b10, mp);
        passo(1, 2'b10, 1, 7, 0, mp);
        ocioso(2, 2'b10, mp);
        passo(1, 2'b10, 1, 0, 5, mp);
        ocioso(2, 2'b10, mp);
        // Miss, then sink the rest -> victory one edge later
        passo(1, 2'b10, 1, 0, 1, mp);
        passo(1, 2'b10, 1, 1, 1, mp);
        ocioso(1, 2'b10, mp);
        passo(1, 2'b10, 1, 2, 2, mp);
        ocioso(4, 2'b10, mp);
        passo(1, 2'b10, 1, 3, 3, mp);
        ocioso(2, 2'b10, mp);
        // One ship at (6,4), sixteen misses -> defeat, confirm ignored afterwards
        mp = '0; mp[34] = 1'b1;
        passo(1, 2'b01, 0, 0, 0, mp);
        passo(1, 2'b01, 1, 0, 0, mp);
        passo(1, 2'b10, 0, 0, 0, mp);
        for (int i = 0; i < 16; i++) passo(1, 2'b10, 1, i / COLUNAS, i % COLUNAS, mp);
        ocioso(2, 2'b10, mp);
        passo(1, 2'b10, 1, 6, 4, mp);
        passo(1, 2'b10, 1, 6, 4, mp);
        ocioso(2, 2'b10, mp);
        // Fifteen misses then the last shot sinks the last ship -> victory
        passo(1, 2'b01, 0, 0, 0, mp);
        passo(1, 2'b10, 0, 0, 0, mp);
        for (int i = 0; i < 15; i++) passo(1, 2'b10, 1, i / COLUNAS, i % COLUNAS, mp);
        passo(1, 2'b10, 1, 6, 4, mp);
        ocioso(3, 2'b10, mp);
        // Switch off in the middle of a flash
        mp = '0; mp[3] = 1'b1; mp[20] = 1'b1;
        passo(1, 2'b01, 0, 0, 0, mp);
        passo(1, 2'b01, 1, 0, 0, mp);
        passo(1, 2'b10, 0, 0, 0, mp);
        passo(1, 2'b10, 1, 0, 3, mp);
        ocioso(2, 2'b10, mp);
        ocioso(3, 2'b00, mp);
        // Reset in the middle of a match
        passo(1, 2'b01, 0, 0, 0, mp);
        passo(1, 2'b01, 1, 0, 0, mp);
        passo(1, 2'b10, 0, 0, 0, mp);
        passo(1, 2'b10, 1, 1, 1, mp);
        passo(0, 2'b10, 0, 0, 0, mp);
        ocioso(2, 2'b10, mp);
        // Attack requested straight from off, then an empty map -> immediate victory
        passo(1, 2'b00, 0, 0, 0, '0);
        ocioso(2, 2'b10, '0);
        passo(1, 2'b01, 0, 0, 0, '0);
        passo(1, 2'b01, 1, 0, 0, '0);
        ocioso(3, 2'b10, '0);
        // Random matches
        for (int i = 0; i < 40; i++) partida_aleatoria();
        ocioso(2, 2'b00, '0);

        @(posedge clock);
        #2;
        checks++;
        if (fila.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", fila.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
